// File: rtl/counter_event_fifo.sv
// Change-capture FIFO: samples cycle_count every enabled clock and queues only
// value changes, each tagged with a free-running 16-bit timestamp.
module counter_event_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         cycle_count,
   input  logic                     sample_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic [15:0]              out_stamp,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic [15:0]              overflow_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] data_mem [DEPTH];
   logic [15:0]      stamp_mem [DEPTH];
   logic [15:0]      stamp_q;
   logic [WIDTH-1:0] prev_q;
   logic             prev_vld;

   logic capture;
   logic push;
   logic pop;
   logic drop;

   // Handshake: an entry transfers on any edge where out_valid && out_ready.
   // out_valid never depends on out_ready, and once high it holds with
   // out_data/out_stamp stable until that transfer or reset.
   assign level     = wr_ptr - rd_ptr;
   assign full      = (level == PW'(DEPTH));
   assign out_valid = (wr_ptr != rd_ptr);
   assign out_data  = out_valid ? data_mem[rd_ptr[AW-1:0]]  : '0;
   assign out_stamp = out_valid ? stamp_mem[rd_ptr[AW-1:0]] : '0;

   assign capture = sample_en && (!prev_vld || (cycle_count != prev_q));
   assign pop     = out_valid && out_ready;
   // A pop on the same edge frees the slot a full FIFO needs; empty never bypasses.
   assign push    = capture && (!full || pop);
   assign drop    = capture && !push;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         stamp_q      <= '0;
         prev_q       <= '0;
         prev_vld     <= 1'b0;
         overflow_cnt <= '0;
      end else begin
         stamp_q <= stamp_q + 16'd1;
         if (sample_en) begin
            prev_q   <= cycle_count;
            prev_vld <= 1'b1;
         end
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (drop && (overflow_cnt != 16'hFFFF)) overflow_cnt <= overflow_cnt + 16'd1;
      end
   end

   // Storage needs no reset: the outputs are gated by out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr[AW-1:0]]  <= cycle_count;
         stamp_mem[wr_ptr[AW-1:0]] <= stamp_q;
      end
   end

endmodule
